// File: rtl/bin_morph_pkg.sv
// bin_morph_pkg: mode encodings, pipeline latency LAT and ones-count width helper tw_width(k) shared by the bin_morph_filter files
package bin_morph_pkg;

    typedef enum logic [1:0] {
        MODE_ERODE  = 2'b00,
        MODE_DILATE = 2'b01,
        MODE_THRESH = 2'b10,
        MODE_PASS   = 2'b11
    } mode_e;

    localparam int LAT = 3;

    function automatic int tw_width(input int k);
        return $clog2(k * k + 1);
    endfunction

endpackage

// File: rtl/bin_line_buffer.sv
// bin_line_buffer: ROWS-row binary line shift buffer of DEPTH columns; ports clk, we, addr, din in, taps out (bit 0 = newest stored row)
module bin_line_buffer #(
    parameter int DEPTH = 640,
    parameter int ROWS  = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic            din,
    output logic [ROWS-1:0] taps
);

    logic [ROWS-1:0] mem [DEPTH];

    assign taps = mem[addr];

    always_ff @(posedge clk)
        if (we) mem[addr] <= {mem[addr][ROWS-2:0], din};

endmodule

// File: rtl/bin_morph_filter.sv
// bin_morph_filter: KSIZE x KSIZE binary erode/dilate/threshold/pass filter, 3-clock latency; ports clk, rst_n, mode, thresh, per_img_vsync/href/bit in, post_img_vsync/href/bit out
module bin_morph_filter
    import bin_morph_pkg::*;
#(
    parameter int   IMG_H_DISP = 640,
    parameter int   IMG_V_DISP = 480,
    parameter int   KSIZE      = 3,
    parameter logic EDGE_VAL   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    input  logic [tw_width(KSIZE)-1:0] thresh,
    input  logic                       per_img_vsync,
    input  logic                       per_img_href,
    input  logic                       per_img_bit,
    output logic                       post_img_vsync,
    output logic                       post_img_href,
    output logic                       post_img_bit
);

    localparam int TW = tw_width(KSIZE);
    localparam int CW = $clog2(IMG_H_DISP);
    localparam int RW = $clog2(IMG_V_DISP);
    localparam int PW = $clog2(KSIZE + 1);
    localparam int C  = (KSIZE - 1) / 2;

    logic [CW-1:0]    col;
    logic             col_ovf;
    logic [RW-1:0]    row;
    logic             vs_d, href_d, armed;
    mode_e            mode_q;
    logic [TW-1:0]    thresh_q;
    logic [LAT-1:0]   vs_sr, hs_sr;
    logic [1:0]       inc_sr;
    logic             ctr;
    logic [KSIZE-2:0] taps;
    logic [KSIZE-1:0] win [KSIZE];
    logic [PW-1:0]    pc_d [KSIZE];
    logic [PW-1:0]    pc [KSIZE];
    logic [TW-1:0]    sum;
    logic             vs_rise, line_end, inc, res;

    assign vs_rise        = per_img_vsync & ~vs_d;
    assign line_end       = href_d & ~per_img_href;
    assign inc            = (row < RW'(KSIZE - 1)) | (col < CW'(KSIZE - 1)) | col_ovf;
    assign post_img_vsync = vs_sr[LAT-1];
    assign post_img_href  = hs_sr[LAT-1];

    bin_line_buffer #(
        .DEPTH(IMG_H_DISP),
        .ROWS (KSIZE - 1)
    ) u_lb (
        .clk (clk),
        .we  (per_img_href & ~col_ovf),
        .addr(col),
        .din (per_img_bit),
        .taps(taps)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            col_ovf  <= 1'b0;
            row      <= '0;
            vs_d     <= 1'b0;
            href_d   <= 1'b0;
            armed    <= 1'b0;
            mode_q   <= MODE_ERODE;
            thresh_q <= '0;
        end else begin
            vs_d   <= per_img_vsync;
            href_d <= per_img_href;
            if (vs_rise) begin
                armed    <= 1'b1;
                mode_q   <= mode_e'(mode);
                thresh_q <= thresh;
            end
            if (!per_img_href) begin
                col     <= '0;
                col_ovf <= 1'b0;
            end else if (col == CW'(IMG_H_DISP - 1)) col_ovf <= 1'b1;
            else col <= col + 1'b1;
            if (vs_rise) row <= '0;
            else if (line_end && row != RW'(IMG_V_DISP - 1)) row <= row + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sr        <= '0;
            hs_sr        <= '0;
            inc_sr       <= '0;
            ctr          <= 1'b0;
            post_img_bit <= 1'b0;
            for (int j = 0; j < KSIZE; j++) begin
                win[j] <= '0;
                pc[j]  <= '0;
            end
        end else begin
            vs_sr  <= {vs_sr[LAT-2:0], per_img_vsync};
            hs_sr  <= {hs_sr[LAT-2:0], per_img_href & armed};
            inc_sr <= {inc_sr[0], inc};
            if (per_img_href) begin
                win[0] <= {taps, per_img_bit};
                for (int j = 1; j < KSIZE; j++) win[j] <= win[j-1];
            end
            pc           <= pc_d;
            ctr          <= win[C][C];
            post_img_bit <= hs_sr[1] & (inc_sr[1] ? EDGE_VAL : res);
        end
    end

    always_comb begin
        for (int i = 0; i < KSIZE; i++) begin
            pc_d[i] = '0;
            for (int j = 0; j < KSIZE; j++) pc_d[i] = pc_d[i] + PW'(win[j][i]);
        end
        sum = '0;
        for (int i = 0; i < KSIZE; i++) sum = sum + TW'(pc[i]);
        res = mode_q == MODE_ERODE  ? sum == TW'(KSIZE * KSIZE) :
              mode_q == MODE_DILATE ? sum != '0 :
              mode_q == MODE_THRESH ? sum >= thresh_q : ctr;
    end

endmodule
